// File: rtl/ma_channel_scheduler.sv
// Round-robin scheduler sharing one moving-average engine among NUM_CH sources.
// Optional: define MA_SCHED_PRIORITY_EN to give channel 0 absolute priority.
module ma_channel_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 31
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         ch_req_i,
    input  logic [NUM_CH*DATA_W-1:0]  ch_data_i,
    output logic [NUM_CH-1:0]         ch_ack_o,
    output logic                      eng_strobe_o,
    output logic [DATA_W-1:0]         eng_data_o,
    input  logic                      eng_done_i,
    input  logic [DATA_W-1:0]         eng_avg_i,
    output logic                      res_valid_o,
    output logic [$clog2(NUM_CH)-1:0] res_ch_o,
    output logic [DATA_W-1:0]         res_data_o,
    output logic                      busy_o,
    output logic                      timeout_err_o
);

    localparam int CW = $clog2(NUM_CH);
    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        CAPTURE
    } state_t;

    state_t              r_state, w_state;
    logic [CW-1:0]       r_grant, w_grant;
    logic [CW-1:0]       r_ptr, w_ptr;
    logic [7:0]          r_timer, w_timer;
    logic [NUM_CH-1:0]   r_ack, w_ack;
    logic                r_strobe, w_strobe;
    logic [DATA_W-1:0]   r_data, w_data;
    logic                r_res_valid, w_res_valid;
    logic [CW-1:0]       r_res_ch, w_res_ch;
    logic [DATA_W-1:0]   r_res_data, w_res_data;
    logic                r_busy, w_busy;
    logic                r_terr, w_terr;

    logic                w_found;
    logic [CW-1:0]       w_pick;
    logic [DATA_W-1:0]   w_sel;
    logic [NUM_CH-1:0]   w_onehot;
    logic [CW-1:0]       w_ptr_inc;
    logic                w_adv;

    // Scan upward from r_ptr first, then wrap around from index 0.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!w_found && ch_req_i[i] && (CW'(i) >= r_ptr)) begin
                w_found = 1'b1;
                w_pick  = CW'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!w_found && ch_req_i[i]) begin
                w_found = 1'b1;
                w_pick  = CW'(i);
            end
        end
`ifdef MA_SCHED_PRIORITY_EN
        if (ch_req_i[0]) begin
            w_found = 1'b1;
            w_pick  = '0;
        end
`endif
    end

    always_comb begin
        w_sel    = '0;
        w_onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_pick == CW'(i)) begin
                w_sel       = ch_data_i[i*DATA_W +: DATA_W];
                w_onehot[i] = 1'b1;
            end
        end
    end

    assign w_ptr_inc = (r_grant == CW'(NUM_CH - 1)) ? '0 : r_grant + CW'(1);

`ifdef MA_SCHED_PRIORITY_EN
    assign w_adv = (r_grant != '0);
`else
    assign w_adv = 1'b1;
`endif

    always_comb begin
        w_state     = r_state;
        w_grant     = r_grant;
        w_ptr       = r_ptr;
        w_timer     = r_timer;
        w_ack       = '0;
        w_strobe    = 1'b0;
        w_data      = r_data;
        w_res_valid = 1'b0;
        w_res_ch    = r_res_ch;
        w_res_data  = r_res_data;
        w_terr      = r_terr;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state  = ISSUE;
                    w_grant  = w_pick;
                    w_data   = w_sel;
                    w_ack    = w_onehot;
                    w_strobe = 1'b1;
                end
            end
            ISSUE: begin
                w_timer = '0;
                w_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                // Done wins over a timeout landing on the same cycle.
                if (eng_done_i) begin
                    w_state = CAPTURE;
                end else if (r_timer == TLAST) begin
                    w_terr  = 1'b1;
                    w_timer = '0;
                    w_ptr   = w_adv ? w_ptr_inc : r_ptr;
                    w_state = IDLE;
                end else begin
                    w_timer = r_timer + 8'd1;
                end
            end
            CAPTURE: begin
                w_res_data  = eng_avg_i;
                w_res_ch    = r_grant;
                w_res_valid = 1'b1;
                w_ptr       = w_adv ? w_ptr_inc : r_ptr;
                w_state     = IDLE;
            end
            default: w_state = IDLE;
        endcase
        w_busy = (w_state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_ptr       <= '0;
            r_timer     <= '0;
            r_ack       <= '0;
            r_strobe    <= 1'b0;
            r_data      <= '0;
            r_res_valid <= 1'b0;
            r_res_ch    <= '0;
            r_res_data  <= '0;
            r_busy      <= 1'b0;
            r_terr      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_grant     <= w_grant;
            r_ptr       <= w_ptr;
            r_timer     <= w_timer;
            r_ack       <= w_ack;
            r_strobe    <= w_strobe;
            r_data      <= w_data;
            r_res_valid <= w_res_valid;
            r_res_ch    <= w_res_ch;
            r_res_data  <= w_res_data;
            r_busy      <= w_busy;
            r_terr      <= w_terr;
        end
    end

    assign ch_ack_o      = r_ack;
    assign eng_strobe_o  = r_strobe;
    assign eng_data_o    = r_data;
    assign res_valid_o   = r_res_valid;
    assign res_ch_o      = r_res_ch;
    assign res_data_o    = r_res_data;
    assign busy_o        = r_busy;
    assign timeout_err_o = r_terr;

endmodule
